// File: rtl/fp_int_mul_ctrl_if.sv
// Bundle of config, input, multiplier-side and result signals for fp_int_mul_ctrl.
// The slave modport is the controller view; the master modport is the
// surrounding system view (config source, producer, multiplier, consumer).
interface fp_int_mul_ctrl_if #(
  parameter int ACT_WIDTH = 16,
  parameter int W_MAX     = 4
);
  // configuration
  logic                 cfg_set;
  logic [3:0]           cfg_precision;
  logic                 cfg_ack;
  logic                 cfg_err;
  // operand input
  logic                 in_valid;
  logic                 in_ready;
  logic [ACT_WIDTH-1:0] in_act;
  logic [W_MAX-1:0]     in_wgt;
  // multiplier drive
  logic [ACT_WIDTH-1:0] mul_act;
  logic                 mul_w;
  logic                 mul_valid;
  logic                 mul_set;
  logic [3:0]           mul_precision;
  // multiplier result
  logic                 mul_sign;
  logic [4:0]           mul_exp;
  logic [13:0]          mul_mant;
  logic                 mul_done;
  // result output and status
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sign;
  logic [4:0]           out_exp;
  logic [13:0]          out_mant;
  logic                 busy;
  logic                 err_timeout;

  modport slave (
    input  cfg_set, cfg_precision, in_valid, in_act, in_wgt,
           mul_sign, mul_exp, mul_mant, mul_done, out_ready,
    output cfg_ack, cfg_err, in_ready, mul_act, mul_w, mul_valid,
           mul_set, mul_precision, out_valid, out_sign, out_exp,
           out_mant, busy, err_timeout
  );

  modport master (
    output cfg_set, cfg_precision, in_valid, in_act, in_wgt,
           mul_sign, mul_exp, mul_mant, mul_done, out_ready,
    input  cfg_ack, cfg_err, in_ready, mul_act, mul_w, mul_valid,
           mul_set, mul_precision, out_valid, out_sign, out_exp,
           out_mant, busy, err_timeout
  );
endinterface

// File: rtl/fp_int_mul_ctrl.sv
// Controller for a bit-serial fp16 x sign-magnitude integer multiplier.
// Accepts one activation/weight pair, streams the weight MSB(sign)-first
// for P cycles, waits for the multiplier result (with a watchdog) and
// holds it on a valid/ready output until taken.
module fp_int_mul_ctrl #(
  parameter int ACT_WIDTH = 16,
  parameter int W_MAX     = 4,
  parameter int TIMEOUT   = 4
) (
  input  logic             clk,
  input  logic             rst,
  fp_int_mul_ctrl_if.slave ctrl_if
);

  localparam int CNT_MAX = (W_MAX > TIMEOUT) ? W_MAX : TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_CFG    = 3'd2;
  localparam logic [2:0] ST_STREAM = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [3:0]           prec_q, prec_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ACT_WIDTH-1:0] act_q, act_d;
  logic [W_MAX-1:0]     wgt_q, wgt_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_sign_q, out_sign_d;
  logic [4:0]           out_exp_q, out_exp_d;
  logic [13:0]          out_mant_q, out_mant_d;
  logic                 err_timeout_q, err_timeout_d;

  logic                 cfg_ok;
  logic                 last_beat;
  logic                 wait_expired;
  logic [3:0]           bit_idx;
  logic [W_MAX-1:0]     wgt_shift;

  assign cfg_ok       = (ctrl_if.cfg_precision >= 4'd2) &&
                        (ctrl_if.cfg_precision <= 4'(W_MAX));
  assign last_beat    = (cnt_q == CW'(prec_q - 4'd1));
  assign wait_expired = (cnt_q == CW'(TIMEOUT - 1));
  // Serial bit select: wgt_q[P-1-cnt], sign first, LSB last.
  assign bit_idx      = prec_q - 4'd1 - 4'(cnt_q);
  assign wgt_shift    = wgt_q >> bit_idx;

  // Next-state and datapath update
  always_comb begin
    state_d       = state_q;
    prec_d        = prec_q;
    cnt_d         = cnt_q;
    act_d         = act_q;
    wgt_d         = wgt_q;
    out_valid_d   = out_valid_q;
    out_sign_d    = out_sign_q;
    out_exp_d     = out_exp_q;
    out_mant_d    = out_mant_q;
    err_timeout_d = err_timeout_q;

    if (out_valid_q && ctrl_if.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_INIT: begin
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (ctrl_if.cfg_set) begin
          state_d = ST_CFG;
        end else if (ctrl_if.in_valid && !out_valid_q) begin
          act_d   = ctrl_if.in_act;
          wgt_d   = ctrl_if.in_wgt;
          cnt_d   = '0;
          state_d = ST_STREAM;
        end
      end
      ST_CFG: begin
        if (cfg_ok) begin
          prec_d = ctrl_if.cfg_precision;
        end
        state_d = ST_IDLE;
      end
      ST_STREAM: begin
        if (last_beat) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT: begin
        if (ctrl_if.mul_done) begin
          out_sign_d  = ctrl_if.mul_sign;
          out_exp_d   = ctrl_if.mul_exp;
          out_mant_d  = ctrl_if.mul_mant;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (wait_expired) begin
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_INIT;
      prec_q        <= 4'(W_MAX);
      cnt_q         <= '0;
      act_q         <= '0;
      wgt_q         <= '0;
      out_valid_q   <= 1'b0;
      out_sign_q    <= 1'b0;
      out_exp_q     <= '0;
      out_mant_q    <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      prec_q        <= prec_d;
      cnt_q         <= cnt_d;
      act_q         <= act_d;
      wgt_q         <= wgt_d;
      out_valid_q   <= out_valid_d;
      out_sign_q    <= out_sign_d;
      out_exp_q     <= out_exp_d;
      out_mant_q    <= out_mant_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Strobes decode from state; gating with rst keeps them quiet while reset is held
  always_comb begin
    ctrl_if.in_ready      = !rst && (state_q == ST_IDLE) && !ctrl_if.cfg_set && !out_valid_q;
    ctrl_if.cfg_ack       = !rst && (state_q == ST_CFG) && cfg_ok;
    ctrl_if.cfg_err       = !rst && (state_q == ST_CFG) && !cfg_ok;
    ctrl_if.mul_set       = !rst && ((state_q == ST_INIT) || ((state_q == ST_CFG) && cfg_ok));
    ctrl_if.mul_precision = ((state_q == ST_CFG) && cfg_ok) ? ctrl_if.cfg_precision : prec_q;
    ctrl_if.mul_valid     = !rst && (state_q == ST_STREAM);
    ctrl_if.mul_w         = !rst && (state_q == ST_STREAM) && wgt_shift[0];
    ctrl_if.mul_act       = (!rst && (state_q == ST_STREAM)) ? act_q : '0;
    ctrl_if.out_valid     = out_valid_q;
    ctrl_if.out_sign      = out_sign_q;
    ctrl_if.out_exp       = out_exp_q;
    ctrl_if.out_mant      = out_mant_q;
    ctrl_if.busy          = (state_q != ST_IDLE);
    ctrl_if.err_timeout   = err_timeout_q;
  end

endmodule

// File: tb/tb_fp_int_mul_ctrl.sv
// Scoreboard bench for fp_int_mul_ctrl with a behavioural serial multiplier.
module tb_fp_int_mul_ctrl;

  logic clk;
  logic rst;

  fp_int_mul_ctrl_if #(.ACT_WIDTH(16), .W_MAX(4)) bus ();

  fp_int_mul_ctrl #(.ACT_WIDTH(16), .W_MAX(4), .TIMEOUT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [4:0]  exp;
    logic [13:0] mant;
  } res_t;

  res_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    end
  endtask

  // Multiplier model: collects the serial weight, answers one cycle after
  // mul_valid falls. Result: sign = act sign ^ weight sign, exp = act exp,
  // mant = {1,act mant} * weight magnitude.
  logic        done_en;
  logic        prev_valid;
  logic [15:0] m_acc;
  int          m_beats;
  logic [15:0] m_act;
  int          m_b;
  logic [31:0] m_mag;
  logic [31:0] m_mant;

  always @(posedge clk) begin
    prev_valid <= rst ? 1'b0 : bus.mul_valid;
    if (bus.mul_valid) begin
      if (!prev_valid) begin
        m_acc   <= {15'b0, bus.mul_w};
        m_beats <= 1;
      end else begin
        m_acc   <= {m_acc[14:0], bus.mul_w};
        m_beats <= m_beats + 1;
      end
      m_act <= bus.mul_act;
    end
  end

  always_comb begin
    m_b          = (m_beats > 0) ? m_beats - 1 : 0;
    m_mag        = {16'b0, m_acc} & ((32'd1 << m_b) - 32'd1);
    m_mant       = (32'h400 | {22'b0, m_act[9:0]}) * m_mag;
    bus.mul_sign = m_act[15] ^ m_acc[m_b[3:0]];
    bus.mul_exp  = m_act[14:10];
    bus.mul_mant = m_mant[13:0];
    bus.mul_done = done_en && prev_valid && !bus.mul_valid && !rst;
  end

  // Monitor: pop and compare on every output handshake
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got out_valid with no expected result at %0t", $time);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("sb_sign", bus.out_sign, e.sign);
        chk("sb_exp",  bus.out_exp,  e.exp);
        chk("sb_mant", bus.out_mant, e.mant);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operand pair, check the serial stream, optionally check latency
  task automatic do_op(input logic [15:0] act, input logic [3:0] wgt, input int p,
                       input bit push, input res_t r, input bit chk_lat, output int waited);
    if (push) exp_q.push_back(r);
    bus.in_valid = 1'b1;
    bus.in_act   = act;
    bus.in_wgt   = wgt;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waited++;
      if (waited > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no in_ready in %0d cycles expected acceptance", waited);
        break;
      end
      tick();
    end
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      chk("stream_mul_valid", bus.mul_valid, 1);
      chk("stream_mul_w", bus.mul_w, wgt[p-1-i]);
      chk("stream_mul_act", bus.mul_act, act);
      tick();
    end
    @(negedge clk);
    chk("wait_mul_valid", bus.mul_valid, 0);
    chk("wait_out_valid", bus.out_valid, 0);
    tick();
    if (chk_lat) begin
      @(negedge clk);
      chk("latency_out_valid", bus.out_valid, 1);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w;
    rst               = 1'b1;
    done_en           = 1'b1;
    bus.cfg_set       = 1'b0;
    bus.cfg_precision = 4'd0;
    bus.in_valid      = 1'b0;
    bus.in_act        = '0;
    bus.in_wgt        = '0;
    bus.out_ready     = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_mul_valid", bus.mul_valid, 0);
    chk("rst_mul_set", bus.mul_set, 0);
    chk("rst_mul_w", bus.mul_w, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_err_timeout", bus.err_timeout, 0);
    chk("rst_cfg_ack", bus.cfg_ack, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("init_mul_set", bus.mul_set, 1);
    chk("init_mul_precision", bus.mul_precision, 4);
    chk("init_in_ready", bus.in_ready, 0);
    tick();
    @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 1);
    chk("idle_mul_set", bus.mul_set, 0);
    tick();

    // P=4: 3C00 x 0101 -> +5 -> mant 0x1400, out_valid in cycle 6
    do_op(16'h3C00, 4'b0101, 4, 1'b1, '{1'b0, 5'h0F, 14'h1400}, 1'b1, w);
    chk("op1_accept_wait", w, 0);

    // Config precision 3
    bus.cfg_set = 1'b1;
    bus.cfg_precision = 4'd3;
    @(negedge clk);
    chk("cfg3_in_ready", bus.in_ready, 0);
    tick();
    bus.cfg_set = 1'b0;
    @(negedge clk);
    chk("cfg3_ack", bus.cfg_ack, 1);
    chk("cfg3_err", bus.cfg_err, 0);
    chk("cfg3_mul_set", bus.mul_set, 1);
    chk("cfg3_mul_precision", bus.mul_precision, 3);
    tick();
    @(negedge clk);
    chk("cfg3_ack_pulse", bus.cfg_ack, 0);
    chk("cfg3_prec_held", bus.mul_precision, 3);
    tick();

    // P=3: 4200 x 111 -> -3 -> mant 0x600*3
    do_op(16'h4200, 4'b0111, 3, 1'b1, '{1'b1, 5'h10, 14'h1200}, 1'b1, w);

    // Rejected precision 7
    bus.cfg_set = 1'b1;
    bus.cfg_precision = 4'd7;
    @(negedge clk);
    tick();
    bus.cfg_set = 1'b0;
    @(negedge clk);
    chk("cfg7_err", bus.cfg_err, 1);
    chk("cfg7_ack", bus.cfg_ack, 0);
    chk("cfg7_mul_set", bus.mul_set, 0);
    tick();
    @(negedge clk);
    chk("cfg7_err_pulse", bus.cfg_err, 0);
    chk("cfg7_prec_kept", bus.mul_precision, 3);
    tick();

    // cfg_set and in_valid together: CFG wins, input taken after return to IDLE
    bus.cfg_set = 1'b1;
    bus.cfg_precision = 4'd3;
    bus.in_valid = 1'b1;
    bus.in_act = 16'hC000;
    bus.in_wgt = 4'b0010;
    @(negedge clk);
    chk("collide_in_ready", bus.in_ready, 0);
    tick();
    bus.cfg_set = 1'b0;
    @(negedge clk);
    chk("collide_cfg_in_ready", bus.in_ready, 0);
    chk("collide_cfg_ack", bus.cfg_ack, 1);
    tick();
    bus.out_ready = 1'b0;
    do_op(16'hC000, 4'b0010, 3, 1'b1, '{1'b1, 5'h10, 14'h0800}, 1'b1, w);
    chk("collide_accept_wait", w, 0);

    // Backpressure: result held, next input blocked
    bus.in_valid = 1'b1;
    bus.in_act = 16'h3800;
    bus.in_wgt = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_out_sign", bus.out_sign, 1);
      chk("bp_out_exp", bus.out_exp, 5'h10);
      chk("bp_out_mant", bus.out_mant, 14'h0800);
      chk("bp_in_ready", bus.in_ready, 0);
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", bus.in_ready, 0);
    tick();
    do_op(16'h3800, 4'b0101, 3, 1'b1, '{1'b1, 5'h0E, 14'h0400}, 1'b1, w);
    chk("bp_next_accept_wait", w, 0);

    // Watchdog: no mul_done; cfg_set during WAIT is ignored
    done_en = 1'b0;
    do_op(16'h3C00, 4'b0011, 3, 1'b0, '{1'b0, 5'h00, 14'h0000}, 1'b0, w);
    bus.cfg_set = 1'b1;
    bus.cfg_precision = 4'd2;
    @(negedge clk);
    chk("wait_cfg_ack", bus.cfg_ack, 0);
    chk("wait_cfg_err", bus.cfg_err, 0);
    chk("wait2_err_timeout", bus.err_timeout, 0);
    chk("wait2_busy", bus.busy, 1);
    tick();
    bus.cfg_set = 1'b0;
    @(negedge clk);
    chk("wait3_err_timeout", bus.err_timeout, 0);
    tick();
    @(negedge clk);
    chk("wait4_err_timeout", bus.err_timeout, 0);
    chk("wait4_busy", bus.busy, 1);
    tick();
    @(negedge clk);
    chk("to_err_timeout", bus.err_timeout, 1);
    chk("to_busy", bus.busy, 0);
    chk("to_out_valid", bus.out_valid, 0);
    chk("to_in_ready", bus.in_ready, 1);
    chk("to_prec_kept", bus.mul_precision, 3);
    tick();
    done_en = 1'b1;

    // Normal op after timeout; flag stays sticky
    do_op(16'h3C00, 4'b0011, 3, 1'b1, '{1'b0, 5'h0F, 14'h0C00}, 1'b1, w);
    chk("sticky_err_timeout", bus.err_timeout, 1);

    // Reset mid-STREAM aborts, reruns INIT with default precision
    bus.in_valid = 1'b1;
    bus.in_act = 16'h4000;
    bus.in_wgt = 4'b0101;
    @(negedge clk);
    chk("abort_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("abort_streaming", bus.mul_valid, 1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_mul_valid", bus.mul_valid, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_init_mul_valid", bus.mul_valid, 0);
    chk("abort_init_mul_set", bus.mul_set, 1);
    chk("abort_init_precision", bus.mul_precision, 4);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_err_cleared", bus.err_timeout, 0);
    tick();
    @(negedge clk);
    chk("abort_idle_in_ready", bus.in_ready, 1);
    chk("abort_idle_busy", bus.busy, 0);
    tick();

    repeat (4) tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
